apb2_master_arbiter: RTL and testbench



---
 rtl/apb2_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_apb2_master_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb2_master_arbiter.sv
// apb2_master_arbiter: round-robin bridge from two req/ack agents onto one APB2 segment.
// Each granted request runs a fixed SETUP -> ACCESS -> DONE sequence and ends with a
// one-cycle ack to the winner. Every output comes straight from a flop, so no input
// can reach an output through combinational logic.
module apb2_master_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,

  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  state_e                  state_q;
  logic                    grant_q;
  logic                    lastGrant_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    busy_q;
  logic                    r0Ack_q;
  logic                    r1Ack_q;
  logic [DATA_WIDTH-1:0]   r0Rdata_q;
  logic [DATA_WIDTH-1:0]   r1Rdata_q;

  logic                    reqAny;
  logic                    grant_d;
  logic [ADDR_WIDTH-1:0]   selAddr;
  logic [DATA_WIDTH-1:0]   selWdata;
  logic                    selWrite;

  // Round-robin pick: a lone request wins outright; on a tie the agent not served last time wins.
  always_comb begin
    reqAny = r0_req | r1_req;
    grant_d = 1'b0;
    if (r0_req && r1_req) begin
      grant_d = ~lastGrant_q;
    end else if (r1_req) begin
      grant_d = 1'b1;
    end
    selAddr  = grant_d ? r1_addr  : r0_addr;
    selWdata = grant_d ? r1_wdata : r0_wdata;
    selWrite = grant_d ? r1_write : r0_write;
  end

  // Transfer sequencer: latches the winner's command at grant, drives the APB phases, returns data and ack.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      busy_q      <= 1'b0;
      r0Ack_q     <= 1'b0;
      r1Ack_q     <= 1'b0;
      r0Rdata_q   <= '0;
      r1Rdata_q   <= '0;
    end else begin
      r0Ack_q <= 1'b0;
      r1Ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqAny) begin
            grant_q     <= grant_d;
            lastGrant_q <= grant_d;
            paddr_q     <= selAddr;
            pwdata_q    <= selWdata;
            pwrite_q    <= selWrite;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (!pwrite_q) begin
            if (grant_q) begin
              r1Rdata_q <= prdata;
            end else begin
              r0Rdata_q <= prdata;
            end
          end
          r0Ack_q <= ~grant_q;
          r1Ack_q <= grant_q;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pwrite   = pwrite_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign busy     = busy_q;
  assign r0_ack   = r0Ack_q;
  assign r1_ack   = r1Ack_q;
  assign r0_rdata = r0Rdata_q;
  assign r1_rdata = r1Rdata_q;

endmodule

// File: tb/tb_apb2_master_arbiter.sv
// tb_apb2_master_arbiter: directed and randomized transfers against a transaction-level model
// of the arbiter (round-robin rule, slave memory contents, per-agent read data).
module tb_apb2_master_arbiter;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       r0_req = 1'b0, r0_write = 1'b0;
  logic [7:0] r0_addr = '0, r0_wdata = '0;
  logic       r1_req = 1'b0, r1_write = 1'b0;
  logic [7:0] r1_addr = '0, r1_wdata = '0;
  logic       r0_ack, r1_ack;
  logic [7:0] r0_rdata, r1_rdata;
  logic [7:0] paddr, pwdata, prdata;
  logic       psel, penable, pwrite, busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] refMem [256];
  logic [7:0] mRdata [2];
  logic       mLast;

  // Slave model: default contents from an address rule, overlaid by anything written
  logic [7:0] slaveMem [256];
  bit         slaveValid [256] = '{default: 1'b0};

  apb2_master_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .pclk(pclk), .presetn(presetn),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .busy(busy)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] defaultData(input logic [7:0] a);
    if (a == 8'hf0) return 8'h5a;
    if (a == 8'h20) return 8'h33;
    return a ^ 8'hc3;
  endfunction

  assign prdata = slaveValid[paddr] ? slaveMem[paddr] : defaultData(paddr);

  // Slave accepts a write at the end of its ACCESS phase
  always @(posedge pclk) begin
    if (psel && penable && pwrite) begin
      slaveMem[paddr]   <= pwdata;
      slaveValid[paddr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int who, input logic rq, input logic wr,
                               input logic [7:0] a, input logic [7:0] d);
    if (who == 0) begin
      r0_req = rq; r0_write = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = rq; r1_write = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  // One complete transfer; called at #1 after an edge with the DUT in IDLE and requests set up
  task automatic doTransfer(input string tag);
    int         win;
    logic [7:0] ea, ed;
    logic       ew;
    if (r0_req && r1_req) win = mLast ? 0 : 1;
    else if (r1_req)      win = 1;
    else                  win = 0;
    ea = (win == 1) ? r1_addr  : r0_addr;
    ed = (win == 1) ? r1_wdata : r0_wdata;
    ew = (win == 1) ? r1_write : r0_write;

    @(negedge pclk);
    checkOutput({tag, ".idle_busy"}, busy, 0);
    checkOutput({tag, ".idle_psel"}, psel, 0);

    @(posedge pclk); #1;
    if (win == 0) begin
      r0_addr = 8'($urandom); r0_wdata = 8'($urandom); r0_write = 1'($urandom);
    end else begin
      r1_addr = 8'($urandom); r1_wdata = 8'($urandom); r1_write = 1'($urandom);
    end

    @(negedge pclk);
    checkOutput({tag, ".setup_psel"}, psel, 1);
    checkOutput({tag, ".setup_penable"}, penable, 0);
    checkOutput({tag, ".setup_paddr"}, paddr, ea);
    checkOutput({tag, ".setup_pwrite"}, pwrite, ew);
    if (ew) checkOutput({tag, ".setup_pwdata"}, pwdata, ed);
    checkOutput({tag, ".setup_busy"}, busy, 1);
    checkOutput({tag, ".setup_acks"}, {r1_ack, r0_ack}, 0);

    @(posedge pclk); @(negedge pclk);
    checkOutput({tag, ".access_psel"}, psel, 1);
    checkOutput({tag, ".access_penable"}, penable, 1);
    checkOutput({tag, ".access_paddr"}, paddr, ea);
    if (ew) checkOutput({tag, ".access_pwdata"}, pwdata, ed);
    checkOutput({tag, ".access_acks"}, {r1_ack, r0_ack}, 0);

    if (ew) refMem[ea] = ed;
    else    mRdata[win] = refMem[ea];
    mLast = (win == 1);

    @(posedge pclk); @(negedge pclk);
    checkOutput({tag, ".done_psel"}, {psel, penable}, 0);
    checkOutput({tag, ".done_ack0"}, r0_ack, (win == 0));
    checkOutput({tag, ".done_ack1"}, r1_ack, (win == 1));
    checkOutput({tag, ".done_rdata0"}, r0_rdata, mRdata[0]);
    checkOutput({tag, ".done_rdata1"}, r1_rdata, mRdata[1]);
    checkOutput({tag, ".done_paddr_held"}, paddr, ea);
    checkOutput({tag, ".done_busy"}, busy, 1);

    @(posedge pclk); #1;
    if (win == 0) r0_req = 1'b0;
    else          r1_req = 1'b0;
  endtask

  // Linear directed sequence followed by a randomized run, all against the model
  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = defaultData(8'(i));
    mRdata[0] = '0;
    mRdata[1] = '0;
    mLast = 1'b1;

    #12;
    checkOutput("reset_outputs", {psel, penable, pwrite, busy, r0_ack, r1_ack}, 0);
    checkOutput("reset_addr_data", {paddr, pwdata, r0_rdata, r1_rdata}, 0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    applyStimulus(0, 1, 1, 8'hf1, 8'hff);
    doTransfer("single_write");

    applyStimulus(1, 1, 0, 8'hf0, 8'h00);
    doTransfer("single_read");

    applyStimulus(0, 1, 0, 8'hf0, 8'h00);
    applyStimulus(1, 1, 0, 8'hf1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      if (!r0_req) applyStimulus(0, 1, 0, 8'hf0, 8'h00);
      if (!r1_req) applyStimulus(1, 1, 0, 8'hf1, 8'h00);
      doTransfer("alternate");
    end

    applyStimulus(0, 1, 0, 8'h20, 8'h00);
    doTransfer("read_33");
    applyStimulus(0, 1, 1, 8'h21, 8'h77);
    doTransfer("write_keeps_rdata");
    checkOutput("rdata_after_write", r0_rdata, 8'h33);

    // Asynchronous reset in the middle of ACCESS
    applyStimulus(1, 1, 0, 8'h42, 8'h00);
    @(negedge pclk);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    checkOutput("pre_reset_in_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    checkOutput("areset_psel_penable", {psel, penable}, 0);
    checkOutput("areset_busy_acks", {busy, r0_ack, r1_ack}, 0);
    checkOutput("areset_rdata", {r0_rdata, r1_rdata}, 0);
    mRdata[0] = '0;
    mRdata[1] = '0;
    mLast = 1'b1;
    applyStimulus(1, 0, 0, 8'h00, 8'h00);
    repeat (2) @(posedge pclk);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    applyStimulus(0, 1, 0, 8'hf0, 8'h00);
    applyStimulus(1, 1, 0, 8'hf1, 8'h00);
    doTransfer("tie_after_reset");
    checkOutput("tie_after_reset_last", mLast, 0);
    doTransfer("tie_after_reset_second");

    // Randomized mix of lone requests, ties, idle gaps
    for (int n = 0; n < 60; n++) begin
      for (int w = 0; w < 2; w++) begin
        if (((w == 0) ? r0_req : r1_req) == 1'b0 && $urandom_range(0, 2) != 0)
          applyStimulus(w, 1, 1'($urandom), 8'h80 + 8'($urandom_range(0, 7)), 8'($urandom));
      end
      if (r0_req || r1_req) begin
        doTransfer("rnd");
      end else begin
        @(negedge pclk);
        checkOutput("rnd_idle_busy", busy, 0);
        checkOutput("rnd_idle_psel", {psel, penable}, 0);
        @(posedge pclk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
